// File: rtl/pic_pkg.sv
// Shared constants, acknowledge FSM encoding and priority helper for the IRQ resolver.
package pic_pkg;

  localparam int unsigned IR_WIDTH = 8;
  localparam logic [2:0] SPURIOUS_CODE = 3'd7;

  typedef enum logic [1:0] {
    AckIdle = 2'd0,
    Ack1    = 2'd1,
    AckGap  = 2'd2,
    Ack2    = 2'd3
  } ack_state_e;

  // Rank of an IR number under rotating priority: 0 is highest, 7 is lowest (IR sp).
  function automatic logic [2:0] prio_rank(input logic [2:0] idx, input logic [2:0] sp);
    return idx - sp - 3'd1;
  endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Rotating-priority encoder: returns the highest-priority set bit, where IR (sp+1) mod 8
// ranks highest and IR sp ranks lowest.
module pic_prio_enc
  import pic_pkg::*;
(
  input  logic [IR_WIDTH-1:0] i_vec,
  input  logic [2:0]          i_sp,
  output logic                o_valid,
  output logic [2:0]          o_index
);

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    logic [2:0] w_idx;
    o_valid = 1'b0;
    o_index = 3'd0;
    for (int k = IR_WIDTH - 1; k >= 0; k--) begin
      w_idx = i_sp + 3'd1 + 3'(k);
      if (i_vec[w_idx]) begin
        o_valid = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/pic_irq_resolver.sv
// Interrupt request resolver: synchronises IR/INTA, maintains IRR/IMR/ISR, picks the
// rotating-priority winner and runs the two-pulse acknowledge handshake.
module pic_irq_resolver
  import pic_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [IR_WIDTH-1:0] i_ir,
  input  logic                i_inta,
  input  logic                i_ltim,
  input  logic                i_freeze,
  input  logic                i_sm,
  input  logic [2:0]          i_sp,
  input  logic                i_wr_imr,
  input  logic                i_clr_imr,
  input  logic [IR_WIDTH-1:0] i_imr_data,
  input  logic [IR_WIDTH-1:0] i_eoi,
  input  logic                i_rd_irr,
  input  logic                i_rd_isr,
  input  logic                i_rd_imr,
  output logic                o_int_req,
  output logic [2:0]          o_code,
  output logic [IR_WIDTH-1:0] o_isrset,
  output logic [IR_WIDTH-1:0] o_busdata
);

  logic [IR_WIDTH-1:0] r_ir_s1, r_ir_s2, r_ir_prev;
  logic                r_inta_s1, r_inta_s2;
  logic [IR_WIDTH-1:0] r_irr, r_imr, r_isr;
  logic [2:0]          r_code;
  logic                r_int_req;
  ack_state_e          r_state;

  logic [IR_WIDTH-1:0] w_rise, w_pending, w_cand, w_ack_mask;
  logic                w_win_valid, w_isr_valid, w_qual, w_ack_start, w_ack_set;
  logic [2:0]          w_win_idx, w_isr_idx;

  // Two-flop synchronisers; INTA idles high so its chain resets to 1.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ir_s1   <= '0;
      r_ir_s2   <= '0;
      r_ir_prev <= '0;
      r_inta_s1 <= 1'b1;
      r_inta_s2 <= 1'b1;
    end else begin
      r_ir_s1   <= i_ir;
      r_ir_s2   <= r_ir_s1;
      r_ir_prev <= r_ir_s2;
      r_inta_s1 <= i_inta;
      r_inta_s2 <= r_inta_s1;
    end
  end

  assign w_rise    = r_ir_s2 & ~r_ir_prev;
  assign w_pending = r_irr & ~r_imr;
  // Special mask mode: only the ISR bit of the requester itself blocks it.
  assign w_cand    = i_sm ? (w_pending & ~r_isr) : w_pending;

  pic_prio_enc u_enc_win (
    .i_vec   (w_cand),
    .i_sp    (i_sp),
    .o_valid (w_win_valid),
    .o_index (w_win_idx)
  );

  pic_prio_enc u_enc_isr (
    .i_vec   (r_isr),
    .i_sp    (i_sp),
    .o_valid (w_isr_valid),
    .o_index (w_isr_idx)
  );

  // Winner qualifies if it strictly outranks the highest in-service level.
  always_comb begin
    w_qual = w_win_valid &
             (i_sm | ~w_isr_valid | (prio_rank(w_win_idx, i_sp) < prio_rank(w_isr_idx, i_sp)));
  end

  assign w_ack_start = (r_state == AckIdle) && !r_inta_s2;
  assign w_ack_set   = w_ack_start && i_freeze && w_qual;
  assign w_ack_mask  = w_ack_set ? (IR_WIDTH'(1) << w_win_idx) : '0;

  // IRR capture: level follows the line, edge latches rises until the line drops or acked.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_irr <= '0;
    end else if (i_freeze) begin
      if (i_ltim) r_irr <= r_ir_s2;
      else        r_irr <= r_ir_s2 & (r_irr | w_rise) & ~w_ack_mask;
    end
  end

  // IMR write port; clear beats write.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)      r_imr <= '0;
    else if (i_clr_imr)  r_imr <= '0;
    else if (i_wr_imr)   r_imr <= i_imr_data;
  end

  // ISR: EOI clears first, so an ack set on the same bit survives.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_isr <= '0;
    else            r_isr <= (r_isr & ~i_eoi) | w_ack_mask;
  end

  // Acknowledge FSM with registered code and int_req.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= AckIdle;
      r_code    <= 3'd0;
      r_int_req <= 1'b0;
    end else begin
      unique case (r_state)
        AckIdle: begin
          if (!r_inta_s2) begin
            r_state   <= Ack1;
            r_int_req <= 1'b0;
            if (i_freeze) r_code <= w_qual ? w_win_idx : SPURIOUS_CODE;
          end else if (i_freeze) begin
            r_int_req <= w_qual;
          end
        end
        Ack1: begin
          r_int_req <= 1'b0;
          if (r_inta_s2) r_state <= AckGap;
        end
        AckGap: begin
          r_int_req <= 1'b0;
          if (!r_inta_s2) r_state <= Ack2;
        end
        Ack2: begin
          r_int_req <= 1'b0;
          if (r_inta_s2) r_state <= AckIdle;
        end
        default: begin
          r_state   <= AckIdle;
          r_int_req <= 1'b0;
        end
      endcase
    end
  end

  // Read mux straight from registers.
  always_comb begin
    if (i_rd_irr)      o_busdata = r_irr;
    else if (i_rd_isr) o_busdata = r_isr;
    else if (i_rd_imr) o_busdata = r_imr;
    else               o_busdata = '0;
  end

  assign o_int_req = r_int_req;
  assign o_code    = r_code;
  assign o_isrset  = r_isr;

endmodule

// File: doc/pic_irq_resolver.md
PIC_IRQ_RESOLVER -- requirements
Module: pic_irq_resolver

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; all state SHALL be clocked by clk rising edge.
REQ-002 clk  input  1  system clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 ir  input  8  raw interrupt request lines IR7..IR0, asynchronous.
REQ-005 inta  input  1  CPU acknowledge, active low, asynchronous.
REQ-006 ltim  input  1  1 = level-triggered IRR, 0 = edge-triggered.
REQ-007 freeze  input  1  1 = IRR updates and resolver enabled, 0 = IRR and winner held.
REQ-008 sm  input  1  special mask mode.
REQ-009 sp  input  3  lowest-priority IR number; highest priority is (sp+1) mod 8.
REQ-010 wr_imr / clr_imr  input  1 each  write IMR from imr_data / clear IMR.
REQ-011 imr_data  input  8  new IMR value.
REQ-012 eoi  input  8  one-cycle mask of ISR bits to clear.
REQ-013 rd_irr / rd_isr / rd_imr  input  1 each  register read selects.
REQ-014 int_req  output  1  interrupt request to CPU, registered.
REQ-015 code  output  3  acknowledged IR number to control core.
REQ-016 isrset  output  8  current ISR contents.
REQ-017 busdata  output  8  read data toward control core.

Function
REQ-018 ir and inta SHALL pass through 2-flop synchronisers; all logic below uses the synchronised versions.
REQ-019 Level mode: irr[i] SHALL equal ir_s[i] each cycle while freeze=1.
REQ-020 Edge mode: irr[i] SHALL set on ir_s[i] 0->1 and clear when ir_s[i]=0 or when IR i is acknowledged.
REQ-021 IMR priority SHALL be clr_imr (-> 8'h00) over wr_imr (-> imr_data).
REQ-022 pending = irr & ~imr; winner = highest rotating-priority pending bit.
REQ-023 Normal mode: int_req SHALL assert one cycle after winner priority is strictly higher than highest ISR bit priority (or ISR empty).
REQ-024 SM mode: ISR bits masked in IMR SHALL NOT block; any pending bit not in ISR qualifies.
REQ-025 Ack FSM states IDLE, ACK1, GAP, ACK2: IDLE->ACK1 on inta_s fall; ACK1->GAP on rise; GAP->ACK2 on fall; ACK2->IDLE on rise.
REQ-026 On IDLE->ACK1: code <= winner, isr[winner] <= 1, irr[winner] cleared (edge mode), int_req <= 0, same cycle.
REQ-027 No qualifying winner at IDLE->ACK1: code <= 3'd7 (spurious), ISR unchanged.
REQ-028 code SHALL hold from ACK1 until next IDLE->ACK1.
REQ-029 eoi clears applied before ack set in the same cycle; ack set wins for its bit.
REQ-030 int_req SHALL stay low outside IDLE; freeze=0 SHALL hold irr and code.
REQ-031 busdata = irr if rd_irr, else isr if rd_isr, else imr if rd_imr, else 8'h00; combinational from registers.
REQ-032 isrset SHALL equal isr continuously.

Reset
REQ-033 reset_n low SHALL immediately set irr=0, isr=0, imr=0, code=0, int_req=0, FSM=IDLE, synchronisers=0 (inta sync=1).
REQ-034 Reset mid-acknowledge SHALL abort the cycle with no ISR bit set after release.

Structure
REQ-035 Package pic_pkg SHALL hold IR_WIDTH=8, SPURIOUS_CODE=3'd7 and the ack-state encoding.
REQ-036 Rotating priority encoding SHALL be sub-module pic_prio_enc (8-bit vector, sp in; valid, index out), instantiated for pending and ISR.

Verification
REQ-037 Edge mode, sp=7, ir=8'h24 rising -> int_req=1; inta pulse pair -> code=2, isrset=8'h04, irr=8'h20.
REQ-038 sp=3, ir=8'h11 -> code=4 (IR4 outranks IR0).
REQ-039 isr=8'h04, IR5 pending, sm=0 -> int_req=0; eoi=8'h04 -> int_req=1 after 1 cycle.
REQ-040 ir pulse removed before inta fall, edge mode -> code=7, isrset unchanged.
REQ-041 wr_imr=1 imr_data=8'hF0 with clr_imr=1 -> rd_imr busdata=8'h00.
REQ-042 reset_n low during ACK2 -> all outputs zero, FSM IDLE, next ack behaves as first.
